queue_reader: RTL and testbench
===============================

# queue_reader

Consumer for the cache controller's request queue. It pops 8-bit request words from the queue's read port (`read_en`/`empty`/`out_data`) and absorbs the queue's one-cycle read latency in a 2-entry skid buffer. It presents each word, in order, to the cache-side dispatch logic over a valid/ready handshake. It sits between the request queue and the cache controller FSM, sustains one request per cycle when the downstream accepts every cycle, and never loses or duplicates a word.

## Interface
- `DATA_W`, 8, width of queue words and request data
- `CNT_W`, 16, width of dispatched-request counter
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `enable`  in  1  1 = may issue new queue reads; 0 = stop reading, finish in-flight work
- `empty`  in  1  queue empty flag, from queue
- `out_data`  in  DATA_W  queue read data, valid the cycle after a `read_en` pop
- `read_en`  out  1  pop request to queue
- `req_valid`  out  1  request word available
- `req_data`  out  DATA_W  request word; stable while `req_valid` is high and `req_ready` is low
- `req_ready`  in  1  downstream accepts the word this cycle
- `idle`  out  1  no buffered word, no read in flight
- `dispatched`  out  CNT_W  count of accepted requests

## Operation
**Queue contract**
- A pop occurs at an edge where `read_en`=1.
- The popped word is on `out_data` for the whole following cycle.
- `empty` reflects queue state after all prior pops.
- `read_en` is never asserted while `empty`=1.

**State**
- `inflight`: 1 bit, set when a pop was issued last cycle.
- 2-entry buffer, `head`/`tail` pointers (1 bit each), `occ` count 0..2.

**Read issue**
- `read_en` = `enable` & ~`empty` & (`occ` + `inflight` − `accept`) < 2, where `accept` = `req_valid` & `req_ready`.
- `read_en` is combinational from registered state and current inputs.

**Capture**
- At every edge where `inflight`=1, write `out_data` into `buf[tail]` and advance `tail`.
- The credit rule guarantees capture never overflows.

**Output**
- `req_valid` = (`occ` != 0). `req_data` = `buf[head]`.
- On `accept`: advance `head`; `dispatched` += 1, wrapping modulo 2^CNT_W.

**Occupancy**
- Next `occ` = `occ` + `inflight` − `accept`.
- Capture and accept in the same edge leave `occ` unchanged.

**Idle**
- `idle` = (`occ` == 0) & ~`inflight`.

**Enable**
- `enable`=0 only gates new pops.
- A word already in flight is still captured and delivered.
- Re-asserting `enable` resumes with no lost words.

**Ordering**
- Strict FIFO: words are delivered in pop order.

## Timing
**Reset**
- `rst`=0 clears `inflight`, `occ`, `head`, `tail` and `dispatched` immediately, independent of `clk`.
- Outputs during and after reset: `read_en`=0 while `rst`=0, `req_valid`=0, `idle`=1, `dispatched`=0. Buffer contents are don't-care.

**Latency**
- Pop at edge N → word in buffer at edge N+1 → `req_valid`=1 during cycle N+1..N+2.
- First-word latency from `empty` falling is 2 edges.

**Throughput**
- With `req_ready` held at 1 and the queue non-empty, `read_en` stays at 1 every cycle and one accept occurs per cycle.

**Full (occ=2)**
- `read_en`=1 only if `accept` occurs this cycle.
- Otherwise `read_en`=0.

**Occ=1 with a read in flight**
- No new pop unless `accept` occurs this cycle.

**Downstream stall**
- While `req_ready`=0, `req_data` and `req_valid` are held.
- The buffer fills to 2, then reads stop.

**Queue empties mid-stream**
- `read_en` drops in the same cycle `empty` rises.
- The buffered words still drain.

**Pointer wrap-around**
- 1-bit pointers wrap freely.

**Counter**
- `dispatched` wraps from 0xFFFF to 0.

**Reset mid-operation**
- Buffered and in-flight words are discarded. The popped queue entries are not restored.
- The first edge after `rst` returns to 1 behaves as if the block had just come out of reset.

## Test plan
- **Reset:** hold `rst`=0, `empty`=0, `enable`=1 → `read_en`=0, `req_valid`=0, `idle`=1, `dispatched`=0; release → `read_en`=1 in the next cycle.
- **Streaming:** queue holds 7,1,3,9; `req_ready`=1 → `read_en` high 4 consecutive cycles; `req_data` sequence 7,1,3,9 on consecutive cycles starting 2 edges after the first pop; `dispatched`=4; `idle`=1 afterward.
- **Backpressure:** 5 words queued, `req_ready`=0 for 10 cycles → exactly 2 pops, `req_valid`=1, `req_data` holds the first word; then `req_ready`=1 → remaining 3 popped, all 5 delivered in order, no duplicates.
- **Alternating ready:** `req_ready` toggles 1/0 every cycle with 6 words → pops throttle, 6 words delivered in order, `read_en` never high while `empty`=1.
- **Enable drop:** `enable` goes to 0 the cycle after a pop → the in-flight word is still delivered, no further `read_en`, `idle` rises; `enable`=1 → streaming resumes with the next word.
- **Reset and wrap:** with 2 words buffered, pulse `rst` low for 3 ns between edges → `req_valid` falls immediately, `occ`=0. Separately, preload `dispatched` to 0xFFFE and accept 3 words → reads 0x0001.

Source files
------------

// File: rtl/queue_reader.sv
// queue_reader: pops request words from the cache request queue and
// presents them in order to the dispatch logic via a 2-entry skid buffer.
`timescale 1ns/1ps
module queue_reader #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              empty,
  input  logic [DATA_W-1:0] out_data,
  output logic              read_en,
  output logic              req_valid,
  output logic [DATA_W-1:0] req_data,
  input  logic              req_ready,
  output logic              idle,
  output logic [CNT_W-1:0]  dispatched
);

  logic              inflight;
  logic              head;
  logic              tail;
  logic [1:0]        occ;
  logic [DATA_W-1:0] buf_q [2];
  logic              accept;
  logic [2:0]        credit;

  assign req_valid = (occ != 2'd0);
  assign req_data  = buf_q[head];
  assign accept    = req_valid & req_ready;
  assign idle      = (occ == 2'd0) & ~inflight;

  // slots committed after this edge: buffered + landing - leaving
  assign credit = {1'b0, occ}
                + {2'b00, inflight}
                - {2'b00, accept};

  // a new pop must still fit once the in-flight word lands
  assign read_en = rst & enable & ~empty
                 & (credit < 3'd2);

  // control state: in-flight flag, pointers, occupancy, counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight   <= 1'b0;
      head       <= 1'b0;
      tail       <= 1'b0;
      occ        <= 2'd0;
      dispatched <= '0;
    end else begin
      inflight <= read_en;
      if (inflight)
        tail <= ~tail;
      if (accept) begin
        head       <= ~head;
        dispatched <= dispatched
                    + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      occ <= occ
           + {1'b0, inflight}
           - {1'b0, accept};
    end
  end

  // word popped last cycle lands in the tail slot
  always_ff @(posedge clk) begin
    if (inflight)
      buf_q[tail] <= out_data;
  end

endmodule

// File: tb/tb_queue_reader.sv
// tb_queue_reader: table-driven streaming vectors plus a queue model
// and in-order scoreboard for stall, enable, reset and wrap cases.
`timescale 1ns/1ps
module tb_queue_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        req_ready = 1'b0;
  logic        empty;
  logic [7:0]  out_data;
  logic        read_en;
  logic        req_valid;
  logic [7:0]  req_data;
  logic        idle;
  logic [15:0] dispatched;

  always #5 clk = ~clk;

  queue_reader #(.DATA_W(8), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .empty      (empty),
    .out_data   (out_data),
    .read_en    (read_en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .idle       (idle),
    .dispatched (dispatched)
  );

  // input source select: directed table or queue model
  logic       use_model = 1'b0;
  logic       endless = 1'b0;
  logic       tbl_empty = 1'b1;
  logic [7:0] tbl_out = 8'h00;
  logic [7:0] mem [256];
  int         rd = 0;
  int         wr = 0;
  logic [7:0] m_out = 8'h00;
  logic       m_empty;

  assign m_empty  = endless ? 1'b0 : (rd == wr);
  assign empty    = use_model ? m_empty : tbl_empty;
  assign out_data = use_model ? m_out : tbl_out;

  int          nchk = 0;
  int          nfail = 0;
  logic        do_pop = 1'b0;
  logic        do_acc = 1'b0;
  int          aidx = 0;
  logic [15:0] exp_disp = 16'd0;
  int          flush_cnt = 0;
  int          flush_seen = 0;

  // queue model: pop at the edge, data valid the following cycle
  always @(posedge clk) begin
    if (use_model && do_pop) begin
      m_out <= mem[rd[7:0]];
      rd    <= rd + 1;
    end
  end

  // mid-cycle monitor: decide pops/accepts and score delivered words
  always @(negedge clk) begin
    if (flush_cnt != flush_seen) begin
      flush_seen = flush_cnt;
      aidx       = rd;
      exp_disp   = 16'd0;
    end
    do_pop = read_en;
    do_acc = req_valid & req_ready;
    if (use_model) begin
      if (m_empty) begin
        nchk++;
        if (read_en) begin
          nfail++;
          $display("FAIL pop_on_empty: read_en=%b required 0", read_en);
        end
      end
      if (do_acc) begin
        nchk++;
        if (req_data !== mem[aidx[7:0]]) begin
          nfail++;
          $display("FAIL order[%0d]: req_data=%h required %h",
                   aidx, req_data, mem[aidx[7:0]]);
        end
        aidx++;
      end
    end
    if (do_acc) exp_disp = exp_disp + 16'd1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr[7:0]] = v;
    wr++;
  endtask

  task automatic drain(input string name, input int budget,
                       input logic tog);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (n < budget && !done) begin
      cyc();
      if (tog) req_ready = ~req_ready;
      @(negedge clk);
      #1;
      done = idle && m_empty && (aidx == rd);
      n++;
    end
    chk({name, "_drain"}, 32'(done), 32'd1);
    chk({name, "_disp"}, 32'(dispatched), 32'(exp_disp));
  endtask

  typedef struct {
    logic        en;
    logic        emp;
    logic [7:0]  od;
    logic        rdy;
    logic        x_re;
    logic        x_v;
    logic [7:0]  x_d;
    logic        x_idle;
    logic [15:0] x_disp;
  } vec_t;

  vec_t tv [7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int stop;
    logic hit;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);

    // queue holds 7,1,3,9; downstream always ready
    tv[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
    tv[1] = '{1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    tv[2] = '{1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 16'd0};
    tv[3] = '{1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 16'd1};
    tv[4] = '{1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 16'd2};
    tv[5] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h09, 1'b0, 16'd3};
    tv[6] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd4};

    // reset held with a non-empty queue and enable high
    rst       = 1'b0;
    enable    = 1'b1;
    tbl_empty = 1'b0;
    req_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_read_en", 32'(read_en), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_dispatched", 32'(dispatched), 32'd0);

    cyc();
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      enable    = tv[i].en;
      tbl_empty = tv[i].emp;
      tbl_out   = tv[i].od;
      req_ready = tv[i].rdy;
      @(negedge clk);
      #1;
      chk($sformatf("s%0d_read_en", i), 32'(read_en), 32'(tv[i].x_re));
      chk($sformatf("s%0d_valid", i), 32'(req_valid), 32'(tv[i].x_v));
      if (tv[i].x_v)
        chk($sformatf("s%0d_data", i), 32'(req_data), 32'(tv[i].x_d));
      chk($sformatf("s%0d_idle", i), 32'(idle), 32'(tv[i].x_idle));
      chk($sformatf("s%0d_disp", i), 32'(dispatched), 32'(tv[i].x_disp));
      cyc();
    end

    // backpressure: 5 words, stalled for 10 cycles
    use_model = 1'b1;
    req_ready = 1'b0;
    base = rd;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    repeat (10) cyc();
    @(negedge clk);
    #1;
    chk("bp_pops", 32'(rd - base), 32'd2);
    chk("bp_valid", 32'(req_valid), 32'd1);
    chk("bp_data", 32'(req_data), 32'h11);
    cyc();
    req_ready = 1'b1;
    drain("bp", 40, 1'b0);
    chk("bp_total", 32'(dispatched), 32'd9);

    // alternating ready with 6 words
    cyc();
    req_ready = 1'b0;
    push(8'hA1); push(8'hA2); push(8'hA3);
    push(8'hA4); push(8'hA5); push(8'hA6);
    drain("alt", 60, 1'b1);
    chk("alt_total", 32'(dispatched), 32'd15);

    // enable drops the cycle after the first pop
    cyc();
    req_ready = 1'b1;
    base = rd;
    push(8'hE1); push(8'hE2); push(8'hE3);
    cyc();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("en%0d_read_en", i), 32'(read_en), 32'd0);
    end
    chk("en_pops", 32'(rd - base), 32'd1);
    chk("en_delivered", 32'(aidx), 32'(rd));
    chk("en_idle", 32'(idle), 32'd1);
    cyc();
    enable = 1'b1;
    drain("en", 30, 1'b0);
    chk("en_total", 32'(dispatched), 32'd18);

    // async reset pulse with two words buffered
    cyc();
    req_ready = 1'b0;
    base = rd;
    push(8'hC1); push(8'hC2); push(8'hC3);
    repeat (6) cyc();
    enable = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_valid", 32'(req_valid), 32'd1);
    chk("pre_rst_pops", 32'(rd - base), 32'd2);
    rst = 1'b0;
    flush_cnt++;
    #1;
    chk("mid_rst_valid", 32'(req_valid), 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_read_en", 32'(read_en), 32'd0);
    chk("mid_rst_disp", 32'(dispatched), 32'd0);
    #2;
    rst = 1'b1;
    cyc();
    enable    = 1'b1;
    req_ready = 1'b1;
    drain("rst", 30, 1'b0);
    chk("rst_total", 32'(dispatched), 32'd1);

    // counter wrap: stream up to 0xFFFE, then three more accepts
    cyc();
    endless = 1'b1;
    stop = rd + (32'(16'hFFFE - exp_disp)) - 1;
    n = 0;
    hit = 1'b0;
    while (n < 70000 && !hit) begin
      @(negedge clk);
      #1;
      hit = read_en && (rd == stop);
      n++;
    end
    chk("wrap_reach", 32'(hit), 32'd1);
    @(posedge clk);
    #1;
    enable  = 1'b0;
    endless = 1'b0;
    wr      = rd;
    drain("pre_wrap", 20, 1'b0);
    chk("pre_wrap_count", 32'(dispatched), 32'h0000FFFE);
    cyc();
    enable = 1'b1;
    push(8'h5A); push(8'h5B); push(8'h5C);
    drain("wrap", 20, 1'b0);
    chk("wrap_count", 32'(dispatched), 32'h00000001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule
